// File: rtl/seq_restoring_divider.sv
// Purpose : iterative unsigned restoring divider, one quotient bit per clock.
// Latency : WIDTH cycles from accepted start to done; 1 cycle for divide-by-zero.
// Backpr. : start is ignored (not queued) while busy=1; accepted again in the done cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset, abandons any operation in flight
//   start        request, sampled only while busy=0
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   busy         high while an iterative divide is running
//   done         one-cycle pulse, results valid from this cycle on
//   quotient     registered quotient (all ones on divide-by-zero)
//   remainder    registered remainder (dividend on divide-by-zero)
//   div_by_zero  registered flag, valid with done

// One-bit full adder cell used to build the trial-subtraction ripple chain.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module seq_restoring_divider #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;        // shifting dividend / quotient register
    logic [WIDTH-1:0] r_q;        // partial remainder
    logic [WIDTH-1:0] d_q;        // captured divisor
    logic [CW-1:0]    cnt_q;      // iteration counter
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;

    // The partial remainder always stays below the divisor, so only its
    // low WIDTH bits are ever non-zero; the shifted value needs WIDTH+1.
    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;
    logic             last_iter;

    assign rs       = {r_q, q_q[WIDTH-1]};
    assign carry[0] = 1'b1;  // two's-complement: invert divisor, add one

    // WIDTH-bit ripple subtractor on the low bits of the shifted remainder.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        fulladder u_fa (
            .a_i (rs[i]),
            .b_i (~d_q[i]),
            .c_i (carry[i]),
            .s_o (diff[i]),
            .c_o (carry[i+1])
        );
    end

    // If the shifted remainder's top bit is set it is at least 2^WIDTH and
    // therefore exceeds any divisor; the low-bit difference is still exact
    // because the true result is below the divisor and fits WIDTH bits.
    assign no_borrow = rs[WIDTH] | carry[WIDTH];
    assign r_d       = no_borrow ? diff : rs[WIDTH-1:0];
    assign q_d       = {q_q[WIDTH-2:0], no_borrow};
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Resolved immediately without iterating.
                            done_q <= 1'b1;
                            dbz_q  <= 1'b1;
                            quo_q  <= '1;
                            rem_q  <= dividend;
                        end else begin
                            q_q     <= dividend;
                            r_q     <= '0;
                            d_q     <= divisor;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        // Final iteration lands straight in the result registers.
                        quo_q   <= q_d;
                        rem_q   <= r_d;
                        dbz_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Purpose : self-checking bench for seq_restoring_divider against an arithmetic model.
// Latency : expects done 16 cycles after an accepted start, 1 cycle for divisor=0.
// Backpr. : exercises ignored starts while busy and back-to-back starts on done.
module tb_seq_restoring_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(16), .CW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge, then scramble the inputs so any
    // reliance on live operands shows up as a wrong result.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    // Cycles from the sample after the start edge until done; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 16'd0 || remainder !== 16'd0) begin
            errors++;
            $display("FAIL reset busy=%b done=%b dbz=%b q=%h r=%h required all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat = 0;
        int busy_cycles = 0;
        start_op(16'd100, 16'd7);
        while (done !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL basic_latency got %0d required 16", lat); end
        checks++;
        if (busy_cycles !== 16) begin errors++; $display("FAIL basic_busy got %0d cycles required 16", busy_cycles); end
        checks++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result q=%0d r=%0d dbz=%b busy=%b required 14 2 0 0",
                     quotient, remainder, div_by_zero, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width done=%b required 0", done); end
    endtask

    task automatic test_corners();
        logic [15:0] ta [3] = '{16'hFFFF, 16'hFFFF, 16'd3};
        logic [15:0] tb [3] = '{16'h0001, 16'hFFFF, 16'd10};
        logic [15:0] tq [3] = '{16'hFFFF, 16'h0001, 16'd0};
        logic [15:0] tr [3] = '{16'h0000, 16'h0000, 16'd3};
        int lat;
        for (int k = 0; k < 3; k++) begin
            start_op(ta[k], tb[k]);
            wait_done(lat);
            checks++;
            if (lat !== 16 || quotient !== tq[k] || remainder !== tr[k]) begin
                errors++;
                $display("FAIL corner%0d lat=%0d q=%h r=%h required 16 %h %h",
                         k, lat, quotient, remainder, tq[k], tr[k]);
            end
            tick();
        end
    endtask

    task automatic test_div_by_zero();
        start_op(16'd5, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || div_by_zero !== 1'b1 ||
            quotient !== 16'hFFFF || remainder !== 16'd5) begin
            errors++;
            $display("FAIL dbz done=%b busy=%b dbz=%b q=%h r=%0d required 1 0 1 ffff 5",
                     done, busy, div_by_zero, quotient, remainder);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 16'hFFFF) begin
            errors++;
            $display("FAIL dbz_hold done=%b busy=%b dbz=%b q=%h required 0 0 1 ffff",
                     done, busy, div_by_zero, quotient);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(16'd1000, 16'd9);
        repeat (5) tick();
        // Request arriving while busy must be dropped.
        dividend = 16'd50; divisor = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        checks++;
        if (lat + 6 !== 16 || quotient !== 16'd111 || remainder !== 16'd1) begin
            errors++;
            $display("FAIL busy_ignore lat=%0d q=%0d r=%0d required 16 111 1",
                     lat + 6, quotient, remainder);
        end
        // Start in the done cycle: accepted with no bubble.
        start_op(16'd50, 16'd3);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept done=%b busy=%b required 0 1", done, busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 16 || quotient !== 16'd16 || remainder !== 16'd2) begin
            errors++;
            $display("FAIL b2b_result lat=%0d q=%0d r=%0d required 16 16 2", lat, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int lat;
        int seen = 0;
        start_op(16'd40000, 16'd123);
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 16'd0 || remainder !== 16'd0) begin
            errors++;
            $display("FAIL midreset busy=%b done=%b dbz=%b q=%h r=%h required all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        repeat (30) begin
            if (done !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles required 0", seen); end
        start_op(16'd40000, 16'd123);
        wait_done(lat);
        checks++;
        if (lat !== 16 || quotient !== 16'd325 || remainder !== 16'd25) begin
            errors++;
            $display("FAIL midreset_fresh lat=%0d q=%0d r=%0d required 16 325 25", lat, quotient, remainder);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, eq, er;
        logic        edbz;
        int          elat, lat, sel;
        logic        hold_bad;
        // Results of the previous completed operation (40000/123).
        logic [15:0] hold_q = 16'd325;
        logic [15:0] hold_r = 16'd25;
        for (int n = 0; n < 2000; n++) begin
            sel = $urandom_range(0, 9);
            a   = 16'($urandom);
            case (sel)
                0: b = 16'd0;
                1: b = 16'd1;
                2: begin a = 16'($urandom_range(0, 16'hFFFE)); b = 16'($urandom_range(a + 1, 16'hFFFF)); end
                3: b = 16'($urandom_range(1, 15));
                4: begin a = 16'($urandom_range(0, 255)); b = 16'($urandom); end
                default: b = 16'($urandom);
            endcase
            if (b == 16'd0) begin
                eq = 16'hFFFF; er = a; edbz = 1'b1; elat = 0;
            end else begin
                eq = a / b; er = a % b; edbz = 1'b0; elat = 16;
            end
            start_op(a, b);
            if (b != 16'd0) begin
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL rnd_done_width n=%0d done=%b required 0", n, done); end
            end
            hold_bad = 1'b0;
            lat = 0;
            while (done !== 1'b1 && lat < 64) begin
                if (quotient !== hold_q || remainder !== hold_r) hold_bad = 1'b1;
                tick();
                lat++;
            end
            if (done !== 1'b1) lat = -1;
            checks++;
            if (hold_bad !== 1'b0) begin errors++; $display("FAIL rnd_hold n=%0d outputs changed before done", n); end
            checks++;
            if (lat !== elat || quotient !== eq || remainder !== er || div_by_zero !== edbz || busy !== 1'b0) begin
                errors++;
                $display("FAIL rnd n=%0d a=%0d b=%0d got lat=%0d q=%0d r=%0d dbz=%b busy=%b required lat=%0d q=%0d r=%0d dbz=%b busy=0",
                         n, a, b, lat, quotient, remainder, div_by_zero, busy, elat, eq, er, edbz);
            end
            if (b != 16'd0) begin
                checks++;
                if (32'(quotient) * 32'(b) + 32'(remainder) !== 32'(a) || remainder >= b) begin
                    errors++;
                    $display("FAIL rnd_invariant n=%0d a=%0d b=%0d q=%0d r=%0d", n, a, b, quotient, remainder);
                end
            end
            hold_q = eq;
            hold_r = er;
            if ($urandom_range(0, 3) == 0 || n == 1999) begin
                tick();
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL rnd_gap_done n=%0d done=%b required 0", n, done); end
                repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_by_zero();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
